// File: rtl/btn_cmd_pkg.sv
// Shared definitions for the button command front end: default timing, command id width,
// symbolic channel ids and the per-channel auto-repeat state encoding.
package btn_cmd_pkg;

  localparam int unsigned DefNBtn          = 3;
  localparam int unsigned DefDebounceCycles = 250000;
  localparam int unsigned DefDasDelay      = 4000000;
  localparam int unsigned DefDasRate       = 1250000;
  localparam int unsigned DefFifoDepth     = 4;

  // Channel ids as wired from the board buttons butt1..butt3
  localparam int unsigned CMD_LEFT   = 0;
  localparam int unsigned CMD_ROTATE = 1;
  localparam int unsigned CMD_RIGHT  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } rep_state_e;

  function automatic int unsigned cmd_id_width(input int unsigned n_btn);
    return (n_btn <= 1) ? 1 : $clog2(n_btn);
  endfunction

endpackage

// File: rtl/btn_cmd_unit_if.sv
// Command stream handshake from btn_cmd_unit to the movement consumer.
interface btn_cmd_unit_if #(
  parameter int unsigned IdW = 2
);

  logic           cmd_valid;
  logic [IdW-1:0] cmd_id;
  logic           cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_id,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_id,
    output cmd_ready
  );

endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce filter and delayed auto-shift FSM.
// event_o pulses for one cycle, aligned with the clock edge that takes the event.
module btn_channel
  import btn_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned DAS_DELAY       = DefDasDelay,
  parameter int unsigned DAS_RATE        = DefDasRate
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_raw_i,
  input  logic repeat_en_i,
  output logic btn_level_o,
  output logic event_o
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepMax = (DAS_DELAY > DAS_RATE) ? DAS_DELAY : DAS_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RepW-1:0] DelayLast = RepW'(DAS_DELAY - 1);
  localparam logic [RepW-1:0] RateLast  = RepW'(DAS_RATE - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  rep_state_e      state_q, state_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            press;
  logic            rep_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      state_q   <= StIdle;
      rep_cnt_q <= '0;
    end else begin
      sync_q    <= {sync_q[0], btn_raw_i};
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // Any cycle where the synced level agrees with the accepted level restarts the filter
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == DbLast) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  assign press = level_d & ~level_q;

  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    rep_fire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press && repeat_en_i) begin
          state_d   = StDelay;
          rep_cnt_d = '0;
        end
      end
      StDelay: begin
        if (!level_q || !repeat_en_i) begin
          state_d   = StIdle;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == DelayLast) begin
          rep_fire  = 1'b1;
          state_d   = StRepeat;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RepW'(1);
        end
      end
      StRepeat: begin
        if (!level_q || !repeat_en_i) begin
          state_d   = StIdle;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == RateLast) begin
          rep_fire  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RepW'(1);
        end
      end
      default: begin
        state_d   = StIdle;
        rep_cnt_d = '0;
      end
    endcase
  end

  assign btn_level_o = level_q;
  assign event_o     = press | rep_fire;

endmodule

// File: rtl/btn_cmd_unit.sv
// Player-input front end: N debounced/auto-repeating button channels feeding a priority
// arbiter, per-channel pending bits and a small command FIFO with a registered head.
module btn_cmd_unit
  import btn_cmd_pkg::*;
#(
  parameter int unsigned N_BTN           = DefNBtn,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned DAS_DELAY       = DefDasDelay,
  parameter int unsigned DAS_RATE        = DefDasRate,
  parameter int unsigned FIFO_DEPTH      = DefFifoDepth
) (
  input  logic             clk_25_175_i,
  input  logic             reset_i,
  input  logic [N_BTN-1:0] btn_raw_i,
  input  logic [N_BTN-1:0] repeat_en_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [7:0]       drop_count_o,
  btn_cmd_unit_if.master   cmd_if
);

  localparam int unsigned IdW  = cmd_id_width(N_BTN);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [N_BTN-1:0] event_w;

  for (genvar g = 0; g < N_BTN; g++) begin : gen_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DAS_DELAY      (DAS_DELAY),
      .DAS_RATE       (DAS_RATE)
    ) u_channel (
      .clk_i      (clk_25_175_i),
      .rst_i      (reset_i),
      .btn_raw_i  (btn_raw_i[g]),
      .repeat_en_i(repeat_en_i[g]),
      .btn_level_o(btn_level_o[g]),
      .event_o    (event_w[g])
    );
  end

  logic [N_BTN-1:0] pending_q, pending_d;
  logic [7:0]       drop_count_q, drop_count_d;
  logic [IdW-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [IdW-1:0]   cmd_id_q, cmd_id_d;

  logic [N_BTN-1:0] grant;
  logic [IdW-1:0]   grant_id;
  logic             any_pending;
  logic             pop;
  logic             push;
  logic [N_BTN-1:0] drops;
  logic [3:0]       n_drop;
  logic [8:0]       drop_sum;
  logic [CntW-1:0]  count_vis;

  assign pop  = cmd_valid_q & cmd_if.cmd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts a push
  assign push = any_pending & ((count_q != CntW'(FIFO_DEPTH)) | pop);

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    any_pending = 1'b0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (pending_q[i] && !any_pending) begin
        grant[i]    = 1'b1;
        grant_id    = IdW'(i);
        any_pending = 1'b1;
      end
    end
  end

  always_comb begin
    drops     = event_w & pending_q & ~(push ? grant : '0);
    pending_d = (pending_q & ~(push ? grant : '0)) | event_w;
    n_drop    = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      n_drop = n_drop + 4'(drops[i]);
    end
    drop_sum     = {1'b0, drop_count_q} + 9'(n_drop);
    drop_count_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // Head register shows the oldest entry that was already stored before this edge
  always_comb begin
    wr_ptr_d    = wr_ptr_q + (push ? PtrW'(1) : '0);
    rd_ptr_d    = rd_ptr_q + (pop ? PtrW'(1) : '0);
    count_d     = count_q + CntW'(push) - CntW'(pop);
    count_vis   = count_q - CntW'(pop);
    cmd_valid_d = (count_vis != '0);
    cmd_id_d    = cmd_valid_d ? mem_q[rd_ptr_d] : cmd_id_q;
  end

  always_ff @(posedge clk_25_175_i or posedge reset_i) begin
    if (reset_i) begin
      pending_q    <= '0;
      drop_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_id_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pending_q    <= pending_d;
      drop_count_q <= drop_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_id_q     <= cmd_id_d;
      if (push) begin
        mem_q[wr_ptr_q] <= grant_id;
      end
    end
  end

  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd_id    = cmd_id_q;
  assign drop_count_o     = drop_count_q;

endmodule

// File: tb/tb_btn_cmd_unit.sv
// Directed bench for btn_cmd_unit with short timing constants and hand-computed expectations.
module tb_btn_cmd_unit;
  import btn_cmd_pkg::*;

  localparam int unsigned NBtn = 3;
  localparam int unsigned IdW  = cmd_id_width(NBtn);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NBtn-1:0] raw = '0;
  logic [NBtn-1:0] rep_en = '0;
  logic [NBtn-1:0] level;
  logic [7:0]      drops;

  btn_cmd_unit_if #(.IdW(IdW)) cmd_if ();

  btn_cmd_unit #(
    .N_BTN          (NBtn),
    .DEBOUNCE_CYCLES(4),
    .DAS_DELAY      (10),
    .DAS_RATE       (3),
    .FIFO_DEPTH     (2)
  ) dut (
    .clk_25_175_i(clk),
    .reset_i     (rst),
    .btn_raw_i   (raw),
    .repeat_en_i (rep_en),
    .btn_level_o (level),
    .drop_count_o(drops),
    .cmd_if      (cmd_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every accepted command, with the cycle it was presented in
  int log_id[$];
  int log_cyc[$];
  always @(negedge clk) begin
    if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      log_id.push_back(int'(cmd_if.cmd_id));
      log_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int base;
  int base_n;
  int saw_level;
  int rep_off[8] = '{8, 18, 21, 24, 27, 30, 33, 36};

  initial begin
    cmd_if.cmd_ready = 1'b1;
    ticks(3);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check_eq("rst_id", 32'(cmd_if.cmd_id), 32'd0);
    check_eq("rst_drops", 32'(drops), 32'd0);
    rst = 1'b0;
    ticks(2);

    // Glitch of 3 cycles must be filtered
    base_n = log_id.size();
    saw_level = 0;
    raw[0] = 1'b1;
    ticks(3);
    raw[0] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (level[0]) saw_level = 1;
    end
    check_eq("glitch_level", 32'(saw_level), 32'd0);
    check_eq("glitch_cmds", 32'(log_id.size() - base_n), 32'd0);
    check_eq("glitch_drops", 32'(drops), 32'd0);

    // Single press, no repeat: one command, valid 8 cycles after the raw rise
    base_n = log_id.size();
    base = cyc;
    raw[1] = 1'b1;
    ticks(7);
    check_eq("press_valid_early", 32'(cmd_if.cmd_valid), 32'd0);
    tick();
    check_eq("press_valid", 32'(cmd_if.cmd_valid), 32'd1);
    check_eq("press_id", 32'(cmd_if.cmd_id), 32'(CMD_ROTATE));
    ticks(12);
    raw[1] = 1'b0;
    ticks(15);
    check_eq("press_count", 32'(log_id.size() - base_n), 32'd1);
    if (log_id.size() > base_n) begin
      check_eq("press_log_id", 32'(log_id[base_n]), 32'd1);
      check_eq("press_latency", 32'(log_cyc[base_n] - base), 32'd8);
    end

    // Auto-repeat on ch2: press, +10, then every 3 until the debounced release
    rep_en[2] = 1'b1;
    base_n = log_id.size();
    base = cyc;
    raw[2] = 1'b1;
    ticks(30);
    raw[2] = 1'b0;
    ticks(30);
    rep_en[2] = 1'b0;
    check_eq("rep_count", 32'(log_id.size() - base_n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (base_n + i < log_id.size()) begin
        check_eq($sformatf("rep_id%0d", i), 32'(log_id[base_n+i]), 32'(CMD_RIGHT));
        check_eq($sformatf("rep_cyc%0d", i), 32'(log_cyc[base_n+i] - base), 32'(rep_off[i]));
      end
    end
    check_eq("rep_drops", 32'(drops), 32'd0);

    // Priority and backpressure
    cmd_if.cmd_ready = 1'b0;
    raw = 3'b111;
    ticks(12);
    check_eq("bp_valid", 32'(cmd_if.cmd_valid), 32'd1);
    check_eq("bp_head", 32'(cmd_if.cmd_id), 32'(CMD_LEFT));
    check_eq("bp_pending", 32'(dut.pending_q), 32'b100);
    base_n = log_id.size();
    cmd_if.cmd_ready = 1'b1;
    ticks(6);
    check_eq("bp_count", 32'(log_id.size() - base_n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (base_n + i < log_id.size())
        check_eq($sformatf("bp_order%0d", i), 32'(log_id[base_n+i]), 32'(i));
    end
    check_eq("bp_drops", 32'(drops), 32'd0);
    raw = '0;
    ticks(10);

    // Coalescing on a full FIFO
    cmd_if.cmd_ready = 1'b0;
    rep_en[0] = 1'b1;
    raw[0] = 1'b1;
    ticks(22);
    check_eq("coal_drop1", 32'(drops), 32'd1);
    ticks(3);
    check_eq("coal_drop2", 32'(drops), 32'd2);
    check_eq("coal_pending", 32'(dut.pending_q), 32'b001);
    check_eq("coal_head", 32'(cmd_if.cmd_id), 32'(CMD_LEFT));
    ticks(800);
    check_eq("coal_sat", 32'(drops), 32'd255);
    ticks(9);
    check_eq("coal_sat_hold", 32'(drops), 32'd255);

    // Async reset between edges, button held through it
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check_eq("arst_drops", 32'(drops), 32'd0);
    check_eq("arst_level", 32'(level), 32'd0);
    cmd_if.cmd_ready = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(7);
    check_eq("arst_fresh_early", 32'(cmd_if.cmd_valid), 32'd0);
    tick();
    check_eq("arst_fresh_valid", 32'(cmd_if.cmd_valid), 32'd1);
    check_eq("arst_fresh_id", 32'(cmd_if.cmd_id), 32'(CMD_LEFT));
    raw = '0;
    rep_en = '0;
    ticks(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
